pipeline_hazard_ctrl: RTL

- Central pipeline control for the 5-stage RV32I core.
- Sits directly upstream of every negedge-clocked pipeline stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) and drives their per-stage ena and synchronous flush (rst) inputs.
- Resolves three hazards:
  - load-use stalls, with bubble insertion;
  - taken-branch flushes;
  - data-memory wait freezes.

---
 rtl/pipeline_hazard_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard control: load-use stalls, branch flushes, data-memory freezes.
// Define PIPELINE_PERF_CNT_EN to add the stall_cycles/flush_events counters.
module pipeline_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             if_ena,
    output logic             id_ena,
    output logic             ex_ena,
    output logic             mem_ena,
    output logic             wb_ena,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             stalled,
`ifdef PIPELINE_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
`endif
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        MWAIT  = 2'd2
    } st_t;

    localparam logic [1:0] LINIT = 2'(LOAD_STALL_CYCLES - 1);

    if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 3 || CNT_W < 1) begin : g_bad_cfg
        $error("pipeline_hazard_ctrl: illegal parameter value");
    end

    st_t        cur, nxt, ret, ret_n, ev;
    logic [1:0] lcnt, lcnt_n;
    logic       load_use, mem_wait;

    assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && id_rs1 == ex_rd) ||
                       (id_uses_rs2 && id_rs2 == ex_rd));
    assign mem_wait = mem_req && !mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur  <= RUN;
            ret  <= RUN;
            lcnt <= 2'd0;
        end else begin
            cur  <= nxt;
            ret  <= ret_n;
            lcnt <= lcnt_n;
        end
    end

    always_comb begin
        if_ena   = 1'b1;
        id_ena   = 1'b1;
        ex_ena   = 1'b1;
        mem_ena  = 1'b1;
        wb_ena   = 1'b1;
        id_flush = 1'b0;
        ex_flush = 1'b0;
        nxt      = cur;
        ret_n    = ret;
        lcnt_n   = lcnt;
        // A released MWAIT behaves exactly like the state it interrupted
        ev       = (cur == MWAIT) ? ret : cur;
        if (rst) begin
            {if_ena, id_ena, ex_ena, mem_ena, wb_ena} = 5'b0;
            id_flush = 1'b1;
            ex_flush = 1'b1;
            nxt      = RUN;
        end else if (mem_wait) begin
            {if_ena, id_ena, ex_ena, mem_ena, wb_ena} = 5'b0;
            nxt = MWAIT;
            if (cur != MWAIT) ret_n = cur;
        end else begin
            nxt = RUN;
            case (ev)
                LSTALL: begin
                    if_ena   = 1'b0;
                    id_ena   = 1'b0;
                    ex_flush = 1'b1;
                    lcnt_n   = lcnt - 2'd1;
                    nxt      = (lcnt == 2'd1) ? RUN : LSTALL;
                end
                default: begin
                    if (ex_branch_taken) begin
                        id_flush = 1'b1;
                        ex_flush = 1'b1;
                    end else if (load_use) begin
                        if_ena   = 1'b0;
                        id_ena   = 1'b0;
                        ex_flush = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            lcnt_n = LINIT;
                            nxt    = LSTALL;
                        end
                    end
                end
            endcase
        end
    end

    assign stalled = !rst && !(if_ena && id_ena && ex_ena && mem_ena && wb_ena);
    assign state   = cur;

`ifdef PIPELINE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stalled && !(&stall_cycles))
                stall_cycles <= stall_cycles + 1'b1;
            if (id_flush && !(&flush_events))
                flush_events <= flush_events + 1'b1;
        end
    end
`endif

endmodule
